// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, used beside the single-cycle ALU in execute.
// Multiplies by shift-add over a 2*XLEN accumulator and divides by restoring
// division on magnitudes, one radix-2 step per cycle. Divide-by-zero and signed
// overflow are resolved at acceptance and complete in one cycle.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-high reset
//   start  - request strobe, sampled only in IDLE
//   md_op  - RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   a, b   - operands rs1 / rs2
//   busy   - high while iterating (cycle after acceptance until done)
//   done   - one-cycle pulse, result valid in the same cycle
//   result - registered result, held until the next done
//   zero   - result == 0
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] SignMin = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OpMul    = 3'b000;
  localparam logic [2:0] OpMulh   = 3'b001;
  localparam logic [2:0] OpMulhsu = 3'b010;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state;
  logic [CntW-1:0]   cnt;
  logic [2:0]        op;
  logic [2*XLEN-1:0] acc;     // mul: product; div: {remainder, dividend/quotient}
  logic [2*XLEN-1:0] mcand;   // mul: extended multiplicand, shifted left each step
  logic [XLEN-1:0]   opb;     // mul: multiplier shifted right; div: divisor magnitude
  logic              b_signed;
  logic              neg_q;
  logic              neg_r;

  // Acceptance-time decode from the live inputs.
  logic            sdiv_in, dzero_in, ovf_in, special_in, a_sgn_in, b_sgn_in;
  logic [XLEN-1:0] abs_a, abs_b, special_res;

  always_comb begin
    sdiv_in    = md_op[2] & ~md_op[0];
    dzero_in   = md_op[2] && (b == '0);
    ovf_in     = sdiv_in && (a == SignMin) && (b == '1);
    special_in = dzero_in || ovf_in;
    if (dzero_in) begin
      special_res = md_op[1] ? a : '1;
    end else begin
      special_res = md_op[1] ? '0 : SignMin;
    end
    a_sgn_in = (md_op == OpMulh) || (md_op == OpMulhsu);
    b_sgn_in = (md_op == OpMulh);
    abs_a    = (sdiv_in && a[XLEN-1]) ? -a : a;
    abs_b    = (sdiv_in && b[XLEN-1]) ? -b : b;
  end

  // One iteration step for the op in flight.
  logic              last;
  logic [2*XLEN-1:0] addend, mul_acc, div_acc, step_acc;
  logic [XLEN:0]     rem_shift, diff;
  logic [XLEN-1:0]   quo, rmd, final_res;

  always_comb begin
    last   = (cnt == CntW'(1));
    addend = opb[0] ? mcand : '0;
    // A signed multiplier's top bit weighs -2^(XLEN-1), so the final step subtracts.
    mul_acc = (last && b_signed) ? (acc - addend) : (acc + addend);

    rem_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff      = rem_shift - {1'b0, opb};
    if (diff[XLEN]) begin
      div_acc = {rem_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      div_acc = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end

    step_acc = op[2] ? div_acc : mul_acc;
    quo      = step_acc[XLEN-1:0];
    rmd      = step_acc[2*XLEN-1:XLEN];

    if (op[2]) begin
      if (op[1]) begin
        final_res = neg_r ? -rmd : rmd;
      end else begin
        final_res = neg_q ? -quo : quo;
      end
    end else if (op == OpMul) begin
      final_res = step_acc[XLEN-1:0];
    end else begin
      final_res = step_acc[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      cnt      <= '0;
      op       <= '0;
      acc      <= '0;
      mcand    <= '0;
      opb      <= '0;
      b_signed <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            op       <= md_op;
            b_signed <= b_sgn_in;
            neg_q    <= sdiv_in & (a[XLEN-1] ^ b[XLEN-1]);
            neg_r    <= sdiv_in & a[XLEN-1];
            if (special_in) begin
              result <= special_res;
              done   <= 1'b1;
              state  <= StDone;
            end else begin
              cnt   <= CntW'(XLEN);
              busy  <= 1'b1;
              state <= StCalc;
              if (md_op[2]) begin
                acc   <= {{XLEN{1'b0}}, abs_a};
                mcand <= '0;
                opb   <= abs_b;
              end else begin
                acc   <= '0;
                mcand <= a_sgn_in ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
                opb   <= b;
              end
            end
          end
        end
        StCalc: begin
          acc <= step_acc;
          cnt <= cnt - CntW'(1);
          if (!op[2]) begin
            mcand <= mcand << 1;
            opb   <= opb >> 1;
          end
          if (last) begin
            result <= final_res;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= StDone;
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  assign zero = (result == '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, handshake and reset
// behaviour, then randomized operations checked against an arithmetic model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'b000;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        busy, done, zero;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .md_op  (md_op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .zero   (zero)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: full-width products from extended operands, SV signed division.
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] x,
                                          input logic [31:0] y);
    logic [63:0] xs, xu, ys, yu, p;
    int sx, sy;
    logic ovf;
    xs  = {{32{x[31]}}, x};
    xu  = {32'h0, x};
    ys  = {{32{y[31]}}, y};
    yu  = {32'h0, y};
    sx  = x;
    sy  = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    p   = 64'h0;
    case (op)
      3'd0: begin p = xu * yu; return p[31:0]; end
      3'd1: begin p = xs * ys; return p[63:32]; end
      3'd2: begin p = xs * yu; return p[63:32]; end
      3'd3: begin p = xu * yu; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return sx / sy;
      end
      3'd5: begin
        if (y == 0) return 32'hFFFF_FFFF;
        return x / y;
      end
      3'd6: begin
        if (y == 0) return x;
        if (ovf) return 32'h0;
        return sx % sy;
      end
      default: begin
        if (y == 0) return x;
        return x % y;
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] x,
                                    input logic [31:0] y);
    if (!op[2]) return 1'b0;
    if (y == 0) return 1'b1;
    return !op[0] && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
  endfunction

  // Issue one operation from IDLE and check busy/done every cycle up to completion.
  // With disturb set, operands change at T5 and a stray start is pulsed at T10.
  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp_r, input bit disturb);
    int exp_lat;
    exp_lat = is_special(op, x, y) ? 1 : 33;
    @(negedge clk);
    md_op = op;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= exp_lat; n++) begin
      if (n > 1) begin
        @(posedge clk);
        #1;
      end
      if (disturb && n == 5) begin
        a     = $urandom;
        b     = $urandom;
        md_op = 3'($urandom);
      end
      if (disturb && n == 10) start = 1'b1;
      if (disturb && n == 11) start = 1'b0;
      check($sformatf("%s busy T%0d", name, n), {31'h0, busy}, {31'h0, n < exp_lat});
      check($sformatf("%s done T%0d", name, n), {31'h0, done}, {31'h0, n == exp_lat});
    end
    check($sformatf("%s result", name), result, exp_r);
    check($sformatf("%s zero", name), {31'h0, zero}, {31'h0, exp_r == 32'h0});
    @(posedge clk);
    #1;
    check($sformatf("%s done cleared", name), {31'h0, done}, 32'h0);
    check($sformatf("%s idle busy", name), {31'h0, busy}, 32'h0);
  endtask

  initial begin
    int d0, d1, d2, k, pulses;
    logic [2:0]  rop;
    logic [31:0] rx, ry;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("reset busy", {31'h0, busy}, 32'h0);
    check("reset done", {31'h0, done}, 32'h0);
    check("reset result", result, 32'h0);
    check("reset zero", {31'h0, zero}, 32'h1);
    @(negedge clk);
    rst = 1'b0;

    do_op("MUL 3*4", 3'd0, 32'd3, 32'd4, 32'h0000_000C, 1'b0);
    do_op("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    do_op("MULH min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    do_op("MULHU max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    do_op("MULHSU -1*max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    do_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    do_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14, 1'b0);
    do_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 32'd2, 1'b0);
    do_op("DIVU 5/0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    do_op("REMU 5/0", 3'd7, 32'd5, 32'd0, 32'd5, 1'b0);
    do_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    do_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
    do_op("DIV disturbed", 3'd4, 32'd123457, 32'hFFFF_FFF5, ref_res(3'd4, 32'd123457,
          32'hFFFF_FFF5), 1'b1);

    // start held high: back-to-back operations.
    @(negedge clk);
    md_op = 3'd0;
    a     = 32'd5;
    b     = 32'd6;
    start = 1'b1;
    d0 = -1;
    d1 = -1;
    d2 = -1;
    k  = 0;
    for (int n = 1; n <= 120 && k < 3; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (k == 0) d0 = n;
        if (k == 1) d1 = n;
        if (k == 2) d2 = n;
        check($sformatf("b2b result %0d", k), result, 32'd30);
        k++;
      end
    end
    start = 1'b0;
    check("b2b first done", d0, 32'd33);
    check("b2b second done", d1, 32'd67);
    check("b2b third done", d2, 32'd101);

    // Reset in the middle of a DIVU.
    @(negedge clk);
    md_op = 3'd5;
    a     = 32'd1000;
    b     = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst busy", {31'h0, busy}, 32'h0);
    check("midrst done", {31'h0, done}, 32'h0);
    check("midrst result", result, 32'h0);
    check("midrst zero", {31'h0, zero}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("midrst no done", pulses, 32'h0);
    do_op("DIV 20/4", 3'd4, 32'd20, 32'd4, 32'd5, 1'b0);

    // Randomized operations against the model.
    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      rx  = $urandom;
      ry  = $urandom;
      case ($urandom_range(0, 9))
        0: ry = 32'h0;
        1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
        2: begin
          rx = $urandom_range(0, 300);
          ry = $urandom_range(1, 20);
          if ($urandom_range(0, 1) == 1) rx = -rx;
          if ($urandom_range(0, 1) == 1) ry = -ry;
        end
        default: ;
      endcase
      do_op($sformatf("rand%0d op%0d %h %h", i, rop, rx, ry), rop, rx, ry,
            ref_res(rop, rx, ry), ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
